// File: rtl/pcr_mix_pkg.sv
// Shared types and constants for the PCR mixing-tree sequencer.
package pcr_mix_pkg;

  localparam int unsigned N_INLETS  = 8;
  localparam int unsigned N_MIXERS  = 7;
  localparam int unsigned N_XFER    = 2;
  localparam int unsigned RUN_CNT_W = 16;

  // Sequencer phases, in run order.
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FILL,
    ST_MIX1,
    ST_XFER1,
    ST_MIX2,
    ST_XFER2,
    ST_MIX3,
    ST_OUT,
    ST_FLUSH
  } state_e;

  // Reagent inlet bit positions.
  localparam int unsigned INLET_TRIS_HCL   = 0;
  localparam int unsigned INLET_KCL        = 1;
  localparam int unsigned INLET_BSA        = 2;
  localparam int unsigned INLET_GELATIN    = 3;
  localparam int unsigned INLET_PRIMER     = 4;
  localparam int unsigned INLET_DNTP       = 5;
  localparam int unsigned INLET_AMPLITAQ   = 6;
  localparam int unsigned INLET_LAMBDA_DNA = 7;

  // Mixers active per tree level (bit i drives m(i+1)).
  localparam logic [N_MIXERS-1:0] MIX_L1_MASK = 7'b0011011;
  localparam logic [N_MIXERS-1:0] MIX_L2_MASK = 7'b0100100;
  localparam logic [N_MIXERS-1:0] MIX_L3_MASK = 7'b1000000;

  // Inter-level transfer valves.
  localparam logic [N_XFER-1:0] XFER_L12_MASK = 2'b01;
  localparam logic [N_XFER-1:0] XFER_L23_MASK = 2'b10;
  localparam logic [N_XFER-1:0] XFER_ALL_MASK = 2'b11;

endpackage

// File: rtl/phase_timer.sv
// Down-counter timing the current sequencer phase; reloaded on every phase entry.
module phase_timer #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero_c
);

  logic [CNT_W-1:0] cnt_q;

  // Load on phase entry, otherwise count down and park at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/pcr_mix_sequencer.sv
// Valve/mixer sequencer for the 8-input, 7-mixer PCR mixing tree.
module pcr_mix_sequencer
  import pcr_mix_pkg::*;
#(
  parameter int unsigned FILL_CYCLES  = 16,
  parameter int unsigned MIX_CYCLES   = 64,
  parameter int unsigned XFER_CYCLES  = 8,
  parameter int unsigned FLUSH_CYCLES = 32,
  parameter int unsigned CNT_W        = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  output logic [7:0]  inlet_valve,
  output logic [6:0]  mixer_en,
  output logic [1:0]  xfer_valve,
  output logic        outlet_valve,
  output logic        flush_valve,
  output logic        result_valid,
  input  logic        result_ready,
  output logic        busy,
  output logic [15:0] run_count
);

  state_e state_q;
  state_e state_d;

  logic             timer_load_c;
  logic [CNT_W-1:0] timer_val_c;
  logic             timer_zero_c;

  logic [N_INLETS-1:0] inlet_d;
  logic [N_MIXERS-1:0] mixer_d;
  logic [N_XFER-1:0]   xfer_d;
  logic                outlet_d;
  logic                flush_d;

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load_c),
    .load_val (timer_val_c),
    .zero_c   (timer_zero_c)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: timed phases advance on timer zero; abort diverts to flush.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start)              state_d = ST_FILL;
      ST_FILL:  if (abort)              state_d = ST_FLUSH;
                else if (timer_zero_c)  state_d = ST_MIX1;
      ST_MIX1:  if (abort)              state_d = ST_FLUSH;
                else if (timer_zero_c)  state_d = ST_XFER1;
      ST_XFER1: if (abort)              state_d = ST_FLUSH;
                else if (timer_zero_c)  state_d = ST_MIX2;
      ST_MIX2:  if (abort)              state_d = ST_FLUSH;
                else if (timer_zero_c)  state_d = ST_XFER2;
      ST_XFER2: if (abort)              state_d = ST_FLUSH;
                else if (timer_zero_c)  state_d = ST_MIX3;
      ST_MIX3:  if (abort)              state_d = ST_FLUSH;
                else if (timer_zero_c)  state_d = ST_OUT;
      ST_OUT:   if (result_ready || abort) state_d = ST_FLUSH;
      ST_FLUSH: if (timer_zero_c)       state_d = ST_IDLE;
      default:                          state_d = ST_IDLE;
    endcase
  end

  // Timer reload value for the phase being entered.
  always_comb begin
    timer_load_c = (state_d != state_q);
    timer_val_c  = '0;
    case (state_d)
      ST_FILL:                    timer_val_c = CNT_W'(FILL_CYCLES - 1);
      ST_MIX1, ST_MIX2, ST_MIX3:  timer_val_c = CNT_W'(MIX_CYCLES - 1);
      ST_XFER1, ST_XFER2:         timer_val_c = CNT_W'(XFER_CYCLES - 1);
      ST_FLUSH:                   timer_val_c = CNT_W'(FLUSH_CYCLES - 1);
      default:                    timer_val_c = '0;
    endcase
  end

  // Actuator decode for the upcoming phase, so the registers track the state.
  always_comb begin
    inlet_d  = '0;
    mixer_d  = '0;
    xfer_d   = '0;
    outlet_d = 1'b0;
    flush_d  = 1'b0;
    case (state_d)
      ST_FILL: begin
        inlet_d[INLET_TRIS_HCL]   = 1'b1;
        inlet_d[INLET_KCL]        = 1'b1;
        inlet_d[INLET_BSA]        = 1'b1;
        inlet_d[INLET_GELATIN]    = 1'b1;
        inlet_d[INLET_PRIMER]     = 1'b1;
        inlet_d[INLET_DNTP]       = 1'b1;
        inlet_d[INLET_AMPLITAQ]   = 1'b1;
        inlet_d[INLET_LAMBDA_DNA] = 1'b1;
      end
      ST_MIX1:  mixer_d  = MIX_L1_MASK;
      ST_XFER1: xfer_d   = XFER_L12_MASK;
      ST_MIX2:  mixer_d  = MIX_L2_MASK;
      ST_XFER2: xfer_d   = XFER_L23_MASK;
      ST_MIX3:  mixer_d  = MIX_L3_MASK;
      ST_OUT:   outlet_d = 1'b1;
      ST_FLUSH: begin
        flush_d = 1'b1;
        xfer_d  = XFER_ALL_MASK;
      end
      default: ;
    endcase
  end

  // Registered actuator and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inlet_valve  <= '0;
      mixer_en     <= '0;
      xfer_valve   <= '0;
      outlet_valve <= 1'b0;
      result_valid <= 1'b0;
      flush_valve  <= 1'b0;
      busy         <= 1'b0;
    end else begin
      inlet_valve  <= inlet_d;
      mixer_en     <= mixer_d;
      xfer_valve   <= xfer_d;
      outlet_valve <= outlet_d;
      result_valid <= outlet_d;
      flush_valve  <= flush_d;
      busy         <= (state_d != ST_IDLE);
    end
  end

  // Completed-run counter; only a handshake counts, saturating at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_count <= '0;
    end else if (state_q == ST_OUT && result_ready && run_count != 16'hFFFF) begin
      run_count <= run_count + RUN_CNT_W'(1);
    end
  end

endmodule

// File: doc/pcr_mix_sequencer.md
# pcr_mix_sequencer

Cycle-accurate valve and mixer sequencer for the 8-input, 7-mixer PCR mixing tree.
- Fills all eight reagent inlets, then runs the three mixer levels in order: m1/m2/m4/m5, then m3/m6, then m7.
- Presents the final mixture to the downstream consumer through a valid/ready handshake, then flushes the tree.
- Sits directly upstream of the mixing tree and drives every actuator in it.

## Interface
- FILL_CYCLES, default 16: inlet-open duration in cycles; legal range ≥1.
- MIX_CYCLES, default 64: duration of each mixer level; legal range ≥1.
- XFER_CYCLES, default 8: inter-level transfer duration; legal range ≥1.
- FLUSH_CYCLES, default 32: flush duration; legal range ≥1.
- CNT_W, default 16: phase counter width; must hold max(parameter)−1.
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a run; sampled only in IDLE.
- abort  in  1  cancel the current run; sampled in every state except IDLE and FLUSH.
- inlet_valve  out  8  reagent inlets. Bit mapping: 0 tris_hcl, 1 kcl, 2 bovine_serum_albumin, 3 gelatin, 4 primer, 5 beosynucletide_triphosphate, 6 amplitag_dna, 7 lambda_dna.
- mixer_en  out  7  mixer drive; bit i drives mixer m(i+1).
- xfer_valve  out  2  bit0 opens the level1→level2 transfer; bit1 opens the level2→level3 transfer.
- outlet_valve  out  1  root outlet; equals result_valid.
- flush_valve  out  1  flush path open.
- result_valid  out  1  mixture available at the outlet.
- result_ready  in  1  downstream accepts the mixture.
- busy  out  1  state ≠ IDLE.
- run_count  out  16  completed (handshaken) runs; saturates at 0xFFFF.

## Operation
- States, in order: IDLE → FILL → MIX1 → XFER1 → MIX2 → XFER2 → MIX3 → OUT → FLUSH → IDLE.
- Actuator outputs per state:
  - FILL: inlet_valve = 0xFF.
  - MIX1: mixer_en = 7'b0011011.
  - XFER1: xfer_valve = 2'b01.
  - MIX2: mixer_en = 7'b0100100.
  - XFER2: xfer_valve = 2'b10.
  - MIX3: mixer_en = 7'b1000000.
  - OUT: outlet_valve = result_valid = 1.
  - FLUSH: flush_valve = 1, all xfer valves = 1, outlet_valve = 0.
  - Every actuator bit not listed for a state is 0.
- Timed states (FILL, MIX1–3, XFER1–2, FLUSH) last exactly their parameter count of cycles:
  - the counter loads N−1 on state entry;
  - the state exits on the cycle the counter reads 0.
- OUT has no timeout. It holds until result_ready=1 is sampled, then goes to FLUSH and increments run_count.
- Transitions from IDLE:
  - start in IDLE → FILL.
  - start outside IDLE is ignored, with no queuing.
  - start and abort together in IDLE: abort has no effect; start is honoured.
- Abort:
  - abort in FILL through OUT → FLUSH next cycle.
  - An aborted run does not increment run_count.
  - If result_ready and abort coincide in OUT, the handshake wins and run_count increments.
- FLUSH always runs its full FLUSH_CYCLES and ignores both abort and start.
- Reset (asynchronous) returns to IDLE and clears run_count to 0 from any state, including mid-run.
  - Every output is 0 during and after reset.
  - No flush is performed; the upstream host is responsible for that.

## Timing
- All outputs are registered (Moore); no combinational path from any input to any output.
- start sampled high at edge k → FILL outputs are visible from cycle k+1.
- result_valid rises at cycle k + 1 + FILL_CYCLES + 3·MIX_CYCLES + 2·XFER_CYCLES.
- Handshake at edge j (valid & ready) → result_valid is 0 and flush_valve is 1 from cycle j+1.
- busy falls at j + 1 + FLUSH_CYCLES.
- A new start is accepted on the first IDLE cycle.
- There are no idle gaps between consecutive states.
- abort sampled at edge a → flush_valve is 1 from cycle a+1.

## Structure
- Package pcr_mix_pkg holds:
  - the state enum;
  - the inlet bit-index constants;
  - the mixer level masks (L1 7'b0011011, L2 7'b0100100, L3 7'b1000000);
  - the xfer masks.
- Sub-module phase_timer: a CNT_W-bit down-counter with load, load value and zero flag. It is instantiated once and reloaded on every state entry.
- The top level contains the FSM, the output decode register and the saturating run counter.

## Test plan
- Nominal run (F=4, M=8, X=2, FL=6), start at cycle 10, result_ready tied high:
  - inlet_valve=0xFF for cycles 11–14;
  - mixer_en=0x1B for cycles 15–22;
  - result_valid for exactly cycle 43;
  - busy low at cycle 50;
  - run_count=1.
- Backpressure: hold result_ready low for 20 cycles in OUT → result_valid and outlet_valve stay high and stable, and no other actuator is active. Releasing result_ready → FLUSH on the next cycle.
- Abort during MIX2 → flush_valve=1 and mixer_en=0 on the next cycle; FLUSH lasts FL cycles; run_count is unchanged.
- start pulsed during MIX1 and during FLUSH → ignored, with no extra run afterwards.
- start pulsed on the first IDLE cycle after FLUSH → FILL on the next cycle.
- Assert rst_n low mid-FILL, asynchronously between edges → all outputs 0 immediately, state IDLE, run_count 0.
- Run counter: force run_count to 0xFFFF, then complete a run → run_count stays 0xFFFF.
